// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address sequencer.
//   LOG2N_DEFAULT / N_DEFAULT : default transform size (4096 points)
//   STAGE_W                   : width of the stage number output
//   OP_SWAP / OP_BFLY         : command opcode encodings
//   fft_seq_state_t           : sequencer state encoding
//   bit_rev()                 : reverse the low 'width' bits of a value
package fft_pkg;

    localparam int LOG2N_DEFAULT = 12;
    localparam int N_DEFAULT     = 1 << LOG2N_DEFAULT;
    localparam int STAGE_W       = 4;

    localparam logic OP_SWAP = 1'b0;
    localparam logic OP_BFLY = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SWAP,
        ST_STAGE,
        ST_DRAIN,
        ST_FINISH
    } fft_seq_state_t;

    // Bits at or above 'width' are returned as zero.
    function automatic logic [15:0] bit_rev(input logic [15:0] x, input int width);
        logic [15:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            if (b < width) begin
                r[width - 1 - b] = x[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_addr_seq_if.sv
// Command / write-back bus between the FFT sequencer and the butterfly datapath.
//   cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_twiddle : command from sequencer
//   cmd_ready : datapath accepts the presented command
//   wb_ack    : one pulse per completed command write-back
// master = sequencer side, slave = datapath side.
interface fft_addr_seq_if #(
    parameter int LOG2N = fft_pkg::LOG2N_DEFAULT
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [LOG2N-1:0] cmd_addr_a;
    logic [LOG2N-1:0] cmd_addr_b;
    logic [LOG2N-2:0] cmd_twiddle;
    logic             wb_ack;

    modport master (
        output cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_twiddle,
        input  cmd_ready, wb_ack
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr_a, cmd_addr_b, cmd_twiddle,
        output cmd_ready, wb_ack
    );
endinterface

// File: rtl/fft_bfly_addr_gen.sv
// Combinational radix-2 DIT butterfly address mapping.
//   s       : stage number (0..LOG2N-1)
//   k       : butterfly index within the stage (0..N/2-1)
//   a, b    : the two RAM addresses of butterfly k (b = a + 2**s)
//   twiddle : twiddle ROM index, j << (LOG2N-1-s) where j = k mod 2**s
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = LOG2N_DEFAULT
) (
    input  logic [STAGE_W-1:0] s,
    input  logic [LOG2N-2:0]   k,
    output logic [LOG2N-1:0]   a,
    output logic [LOG2N-1:0]   b,
    output logic [LOG2N-2:0]   twiddle
);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] grp;
    logic [LOG2N-1:0] tw_full;
    logic [4:0]       grp_shift;

    always_comb begin
        k_ext     = {1'b0, k};
        half      = LOG2N'(1) << s;
        j         = k_ext & (half - LOG2N'(1));
        grp       = k_ext >> s;
        // Widened so that s+1 cannot wrap for the largest stage.
        grp_shift = {1'b0, s} + 5'd1;
        a         = (grp << grp_shift) | j;
        // Bit s of a is always clear, so OR is the same as adding half.
        b         = a | half;
        tw_full   = j << (LOG2N - 1 - int'(s));
        twiddle   = tw_full[LOG2N-2:0];
    end

endmodule

// File: rtl/fft_addr_seq.sv
// In-place radix-2 DIT FFT address sequencer.
// Runs one bit-reversal swap pass, then LOG2N butterfly stages, issuing one
// command per handshake and draining outstanding write-backs between passes.
//   clk, reset : clock, asynchronous active-high reset
//   start      : begin a transform (accepted only in IDLE)
//   busy       : transform in progress
//   done       : one-cycle pulse after the final write-back
//   stage      : current butterfly stage (0 during swap pass and IDLE)
//   cmd        : command / write-back bus (master side)
module fft_addr_seq
    import fft_pkg::*;
#(
    parameter int LOG2N   = LOG2N_DEFAULT,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [STAGE_W-1:0] stage,
    fft_addr_seq_if.master     cmd
);

    localparam int OUT_W = $clog2(MAX_OUT + 1);

    fft_seq_state_t     state_reg, state_next;
    fft_seq_state_t     drain_to_reg, drain_to_next;
    logic               first_stage_reg, first_stage_next;
    logic [STAGE_W-1:0] stage_reg, stage_next;
    // Extra MSB flags that the sweep has passed its last index.
    logic [LOG2N:0]     idx_reg, idx_next;
    logic [LOG2N-1:0]   k_reg, k_next;
    logic [OUT_W-1:0]   out_reg, out_next;

    logic               cmd_valid_reg, cmd_valid_next;
    logic               cmd_op_reg, cmd_op_next;
    logic [LOG2N-1:0]   cmd_a_reg, cmd_a_next;
    logic [LOG2N-1:0]   cmd_b_reg, cmd_b_next;
    logic [LOG2N-2:0]   cmd_tw_reg, cmd_tw_next;

    logic               xfer;
    logic               ack_eff;
    logic               slot_free;
    logic               can_issue;
    logic [LOG2N-1:0]   idx_low;
    logic [LOG2N-1:0]   idx_rev;
    logic [LOG2N-1:0]   gen_a;
    logic [LOG2N-1:0]   gen_b;
    logic [LOG2N-2:0]   gen_tw;

    assign idx_low = idx_reg[LOG2N-1:0];

    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
        assign idx_rev[gi] = idx_low[LOG2N-1-gi];
    end

    fft_bfly_addr_gen #(.LOG2N(LOG2N)) u_gen (
        .s       (stage_reg),
        .k       (k_reg[LOG2N-2:0]),
        .a       (gen_a),
        .b       (gen_b),
        .twiddle (gen_tw)
    );

    assign xfer      = cmd_valid_reg & cmd.cmd_ready;
    // Acks arriving with nothing in flight are spurious and dropped.
    assign ack_eff   = cmd.wb_ack & (out_reg != '0);
    assign slot_free = ~cmd_valid_reg | xfer;

    always_comb begin
        out_next = out_reg;
        if (xfer && !ack_eff) begin
            out_next = out_reg + 1'b1;
        end else if (!xfer && ack_eff) begin
            out_next = out_reg - 1'b1;
        end
    end

    // A command is only loaded if it still fits once it is accepted, so a
    // presented command never has to be withdrawn.
    assign can_issue = (out_next < OUT_W'(MAX_OUT));

    always_comb begin
        state_next       = state_reg;
        drain_to_next    = drain_to_reg;
        first_stage_next = first_stage_reg;
        stage_next       = stage_reg;
        idx_next         = idx_reg;
        k_next           = k_reg;
        cmd_valid_next   = cmd_valid_reg & ~xfer;
        cmd_op_next      = cmd_op_reg;
        cmd_a_next       = cmd_a_reg;
        cmd_b_next       = cmd_b_reg;
        cmd_tw_next      = cmd_tw_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next       = ST_SWAP;
                    idx_next         = '0;
                    k_next           = '0;
                    stage_next       = '0;
                    first_stage_next = 1'b1;
                end
            end

            ST_SWAP: begin
                if (idx_reg[LOG2N]) begin
                    if (slot_free) begin
                        state_next    = ST_DRAIN;
                        drain_to_next = ST_STAGE;
                    end
                end else if (idx_low >= idx_rev) begin
                    // Self-paired or already-swapped index: skip.
                    idx_next = idx_reg + 1'b1;
                end else if (slot_free && can_issue) begin
                    cmd_valid_next = 1'b1;
                    cmd_op_next    = OP_SWAP;
                    cmd_a_next     = idx_low;
                    cmd_b_next     = idx_rev;
                    cmd_tw_next    = '0;
                    idx_next       = idx_reg + 1'b1;
                end
            end

            ST_STAGE: begin
                if (k_reg[LOG2N-1]) begin
                    if (slot_free) begin
                        state_next    = ST_DRAIN;
                        drain_to_next = (stage_reg == STAGE_W'(LOG2N - 1)) ? ST_FINISH : ST_STAGE;
                    end
                end else if (slot_free && can_issue) begin
                    cmd_valid_next = 1'b1;
                    cmd_op_next    = OP_BFLY;
                    cmd_a_next     = gen_a;
                    cmd_b_next     = gen_b;
                    cmd_tw_next    = gen_tw;
                    k_next         = k_reg + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (out_reg == '0) begin
                    state_next = drain_to_reg;
                    if (drain_to_reg == ST_STAGE) begin
                        k_next           = '0;
                        first_stage_next = 1'b0;
                        // The swap pass hands over to stage 0 itself.
                        stage_next       = first_stage_reg ? '0 : stage_reg + 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                state_next = ST_IDLE;
                stage_next = '0;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            drain_to_reg    <= ST_IDLE;
            first_stage_reg <= 1'b0;
            stage_reg       <= '0;
            idx_reg         <= '0;
            k_reg           <= '0;
            out_reg         <= '0;
            cmd_valid_reg   <= 1'b0;
            cmd_op_reg      <= OP_SWAP;
            cmd_a_reg       <= '0;
            cmd_b_reg       <= '0;
            cmd_tw_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            drain_to_reg    <= drain_to_next;
            first_stage_reg <= first_stage_next;
            stage_reg       <= stage_next;
            idx_reg         <= idx_next;
            k_reg           <= k_next;
            out_reg         <= out_next;
            cmd_valid_reg   <= cmd_valid_next;
            cmd_op_reg      <= cmd_op_next;
            cmd_a_reg       <= cmd_a_next;
            cmd_b_reg       <= cmd_b_next;
            cmd_tw_reg      <= cmd_tw_next;
        end
    end

    assign busy  = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
    assign done  = (state_reg == ST_FINISH);
    assign stage = stage_reg;

    assign cmd.cmd_valid   = cmd_valid_reg;
    assign cmd.cmd_op      = cmd_op_reg;
    assign cmd.cmd_addr_a  = cmd_a_reg;
    assign cmd.cmd_addr_b  = cmd_b_reg;
    assign cmd.cmd_twiddle = cmd_tw_reg;

endmodule

// File: doc/fft_addr_seq.md
Name: fft_addr_seq

Overview:
- Sequences the in-place radix-2 DIT FFT over the 4096-entry sample RAM: one bit-reversal swap pass, then LOG2N butterfly stages.
- Issues one command per accepted handshake to the butterfly/RAM datapath: two RAM addresses plus a twiddle index.
- Tracks outstanding write-backs so that no stage starts before the previous stage's results are in RAM.
- Sits between the top-level start/done interface of fft_4096 and its butterfly unit.

Parameters:
- LOG2N, 12, log2 of transform length (N = 2**LOG2N, 4096 by default).
- MAX_OUT, 8, maximum commands in flight (issued, write-back not yet acknowledged).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a transform; ignored unless in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last write-back of the last stage is acknowledged
- stage  out  4  current stage (0..LOG2N-1); 0 during the swap pass and IDLE
- cmd_valid  out  1  command presented
- cmd_ready  in  1  datapath accepts command (transfer = cmd_valid & cmd_ready)
- cmd_op  out  1  0 = SWAP (exchange mem[a] and mem[b]), 1 = BFLY
- cmd_addr_a  out  LOG2N  first RAM address
- cmd_addr_b  out  LOG2N  second RAM address
- cmd_twiddle  out  LOG2N-1  twiddle ROM index (BFLY only; 0 for SWAP)
- wb_ack  in  1  one pulse per completed command write-back

Behaviour:
- Reset values: busy=0, done=0, stage=0, cmd_valid=0, cmd_op=0, all address/twiddle outputs 0. Internal state: IDLE, counters 0, outstanding 0.
- States: IDLE, SWAP, STAGE, DRAIN, FINISH.
- IDLE -> SWAP on start. Index i and stage are cleared.
- SWAP: i sweeps 0..N-1.
  - For each i with i < rev(i) (bit-reverse over LOG2N bits), present SWAP with a=i, b=rev(i).
  - Indices with i >= rev(i) are skipped without a handshake, one index per cycle.
  - After i=N-1, go to DRAIN with next=STAGE(0).
- STAGE s: butterfly index k sweeps 0..N/2-1.
  - half = 1<<s; j = k & (half-1); grp = k >> s.
  - a = (grp << (s+1)) | j; b = a + half; twiddle = j << (LOG2N-1-s).
  - After k=N/2-1 is accepted, go to DRAIN. next = STAGE(s+1), or FINISH if s = LOG2N-1.
- DRAIN: cmd_valid=0. Wait until outstanding = 0, then move to next (stage increments on entry to a new STAGE).
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Command stability: cmd_valid and all command fields are registered. Once cmd_valid=1 they hold stable until transfer. The next command may be presented the cycle after transfer, giving one command per cycle at full throughput.
- Outstanding counter:
  - +1 on transfer, -1 on wb_ack; transfer and wb_ack in the same cycle leave it unchanged.
  - When outstanding = MAX_OUT and no wb_ack is present, cmd_valid is deasserted (never presented, not withdrawn).
  - A wb_ack with outstanding = 0 is ignored and the counter saturates at 0.
- start while busy is ignored. start in the same cycle as FINISH is ignored; a new start is accepted from the following cycle.
- Asserting reset mid-transform aborts immediately to reset values. RAM contents are undefined afterwards.
- Total BFLY commands = LOG2N*N/2 (24576 by default). Total SWAP commands = (N - number of palindromic indices)/2 (2016 for N=4096).

Decomposition:
- Package fft_pkg: LOG2N default, N, op encodings OP_SWAP/OP_BFLY, state enum fft_seq_state_t, bit-reverse function.
- One natural sub-module, fft_bfly_addr_gen: combinational mapping (s, k) -> (a, b, twiddle), reusable by the bench as a reference model.

Test Plan:
1. LOG2N=4, cmd_ready tied 1, wb_ack looped back one cycle after transfer.
   -> SWAP pairs exactly (1,8),(2,4),(3,12),(5,10),(7,14),(11,13).
   -> Then 32 BFLY commands. Stage 0 starts (0,1,tw0),(2,3,tw0). Stage 3 starts (0,8,tw0),(1,9,tw1).
   -> done pulses once and busy falls in the same cycle.
2. LOG2N=4, cmd_ready random 50%.
   -> Command fields never change while cmd_valid=1 and cmd_ready=0; the command sequence is identical to scenario 1.
3. MAX_OUT=2, wb_ack withheld for 20 cycles.
   -> Exactly 2 transfers occur, then cmd_valid stays 0. Issue resumes the cycle after the first wb_ack.
   -> stage never advances while outstanding > 0.
4. start pulsed mid-stage 2, plus start coincident with the FINISH cycle.
   -> Both are ignored: no restart, single done, counters unaffected.
5. reset asserted mid-stage 1 while outstanding=3.
   -> All outputs go to reset values asynchronously. A following start produces the full scenario-1 sequence from the SWAP of (1,8).
6. Default LOG2N=12 with looped-back acks.
   -> Exactly 2016 SWAP and 24576 BFLY commands, 12 stage values 0..11, one done.
   -> fft_4096 RAM dump matches the reference FFT output file.
